// File: rtl/regfile_32x32.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// Register 0 always reads zero; asynchronous active-low reset clears all storage.
module regfile_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NREGS];

    // Entry 0 is cleared by reset and never written; reads of address 0 are also forced to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // No write-to-read bypass: a same-cycle write becomes visible only after the edge.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) rdata1 = regs[raddr1];
        if (raddr2 != '0) rdata2 = regs[raddr2];
    end

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed self-checking bench for regfile_32x32: reset hold, write/read, enable gating,
// register zero, asynchronous reset, full sweep and same-address read/write ordering.
module tb_regfile_32x32;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    int errors = 0;
    int checks = 0;

    regfile_32x32 #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // Rising edges at 5, 15, 25, ... ns
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        logic [31:0] exp;

        // Reset hold: writes presented during reset must be ignored.
        rst    = 1'b0;
        we     = 1'b1;
        waddr  = 5'd21;
        wdata  = 32'hABCDEF12;
        raddr1 = 5'd21;
        raddr2 = 5'd10;
        #2;
        check("reset_r1_t2", rdata1, 32'h0);
        check("reset_r2_t2", rdata2, 32'h0);
        #8;
        waddr = 5'd10;
        wdata = 32'h12345678;
        #2;
        check("reset_r1_t12", rdata1, 32'h0);
        check("reset_r2_t12", rdata2, 32'h0);
        #20;
        check("reset_r1_t32", rdata1, 32'h0);
        check("reset_r2_t32", rdata2, 32'h0);
        #8;
        rst = 1'b1;
        we  = 1'b0;
        #2;
        check("post_reset_r1", rdata1, 32'h0);
        check("post_reset_r2", rdata2, 32'h0);
        tick();
        check("post_reset_edge_r1", rdata1, 32'h0);
        check("post_reset_edge_r2", rdata2, 32'h0);

        // Basic write/read
        we    = 1'b1;
        waddr = 5'd21;
        wdata = 32'hABCDEF12;
        tick();
        check("write21_r1", rdata1, 32'hABCDEF12);
        waddr = 5'd10;
        wdata = 32'h12345678;
        tick();
        check("write10_r2", rdata2, 32'h12345678);
        check("write10_r1_kept", rdata1, 32'hABCDEF12);

        // Write-enable gating
        we    = 1'b0;
        waddr = 5'd21;
        wdata = 32'hFFFFFFFF;
        repeat (3) tick();
        check("we0_r1", rdata1, 32'hABCDEF12);
        check("we0_r2", rdata2, 32'h12345678);

        // Register zero ignores writes
        we     = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'hDEADBEEF;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        tick();
        check("zero_r1", rdata1, 32'h0);
        check("zero_r2", rdata2, 32'h0);
        we = 1'b0;

        // Asynchronous reset between edges
        raddr1 = 5'd21;
        raddr2 = 5'd10;
        #1;
        check("pre_async_r1", rdata1, 32'hABCDEF12);
        check("pre_async_r2", rdata2, 32'h12345678);
        rst = 1'b0;
        #1;
        check("async_r1", rdata1, 32'h0);
        check("async_r2", rdata2, 32'h0);
        #5;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check("after_async_r1", rdata1, 32'h0);
            check("after_async_r2", rdata2, 32'h0);
        end

        // Full sweep with old/new visibility around each write edge
        tick();
        we = 1'b1;
        for (int i = 1; i < 32; i++) begin
            exp    = 32'h01010101 * 32'(i);
            waddr  = 5'(i);
            wdata  = exp;
            raddr1 = 5'(i);
            raddr2 = 5'(i);
            #1;
            check("sweep_before_edge", rdata1, 32'h0);
            tick();
            check("sweep_after_edge_r1", rdata1, exp);
            check("sweep_after_edge_r2", rdata2, exp);
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check("readback_r1", rdata1, 32'h01010101 * 32'(i));
            check("readback_r2", rdata2, 32'h01010101 * 32'(31 - i));
        end

        // Overwrite an existing value: old visible before the edge, new after
        we     = 1'b1;
        waddr  = 5'd7;
        wdata  = 32'hCAFEF00D;
        raddr1 = 5'd7;
        raddr2 = 5'd8;
        #1;
        check("overwrite_old", rdata1, 32'h07070707);
        tick();
        check("overwrite_new", rdata1, 32'hCAFEF00D);
        check("overwrite_neighbor", rdata2, 32'h08080808);
        we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
